clock_display_scan: RTL and testbench

- Downstream consumer of the alarm clock core's time outputs (hours, mins, secs, buzzer).
- Drives a 6-digit, common-anode, multiplexed 7-segment display in HH.MM.SS format.
- Converts binary time fields to decimal digits and scans one digit at a time.
- Blanks the display in a slow blink while the alarm buzzer is active.
- Snapshots its inputs once per scan frame so a displayed frame never mixes old and new time.

---
 rtl/clock_display_scan_if.sv | 21 ++
 rtl/clock_display_scan.sv | 159 +++++++++++++++
 tb/tb_clock_display_scan.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/clock_display_scan_if.sv
// Time bus from the alarm clock core plus the multiplexed display drive.
// master: time source / display observer, slave: clock_display_scan.
interface clock_display_scan_if;
    logic [4:0] hours;
    logic [5:0] mins;
    logic [5:0] secs;
    logic       buzzer;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output hours, mins, secs, buzzer,
        input  an, seg, dp
    );

    modport slave (
        input  hours, mins, secs, buzzer,
        output an, seg, dp
    );
endinterface

// File: rtl/clock_display_scan.sv
// 6-digit HH.MM.SS multiplexed 7-seg scanner, blinks while buzzer is set.
// Ports: clk, reset (sync, active-high), bus (slave: time in, an/seg/dp out).
module clock_display_scan #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    clock_display_scan_if.slave  bus
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
    localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);
    localparam logic [6:0]    SEG_DASH  = 7'b0111111;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          blink_q, blink_d;
    logic [4:0]    hours_q, hours_d;
    logic [5:0]    mins_q, mins_d;
    logic [5:0]    secs_q, secs_d;
    logic          buzz_q, buzz_d;
    logic [5:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          wrap_digit;
    logic          wrap_frame;
    logic [5:0]    field;
    logic          field_ok;
    logic          tens_sel;
    logic [5:0]    digit;

    function automatic logic [6:0] enc(input logic [5:0] d);
        logic [6:0] s;
        case (d)
            6'd0:    s = 7'b1000000;
            6'd1:    s = 7'b1111001;
            6'd2:    s = 7'b0100100;
            6'd3:    s = 7'b0110000;
            6'd4:    s = 7'b0011001;
            6'd5:    s = 7'b0010010;
            6'd6:    s = 7'b0000010;
            6'd7:    s = 7'b1111000;
            6'd8:    s = 7'b0000000;
            6'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Scan timing, per-frame snapshot and blink bookkeeping.
    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        blink_d = blink_q;
        hours_d = hours_q;
        mins_d  = mins_q;
        secs_d  = secs_q;
        buzz_d  = buzz_q;

        wrap_digit = (cnt_q == CNT_MAX);
        wrap_frame = wrap_digit && (idx_q == 3'd5);

        if (wrap_digit) begin
            cnt_d = '0;
            idx_d = wrap_frame ? 3'd0 : idx_q + 3'd1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        if (wrap_frame) begin
            hours_d = bus.hours;
            mins_d  = bus.mins;
            secs_d  = bus.secs;
            buzz_d  = bus.buzzer;
            // Clearing on the capture edge makes the very next
            // frame visible once the buzzer is sampled low.
            if (!bus.buzzer) begin
                frame_d = '0;
                blink_d = 1'b0;
            end else if (buzz_q) begin
                if (frame_q == FRAME_MAX) begin
                    frame_d = '0;
                    blink_d = ~blink_q;
                end else begin
                    frame_d = frame_q + 1'b1;
                end
            end
        end
    end

    // Digit selection and decimal conversion from the snapshot.
    always_comb begin
        field    = '0;
        field_ok = 1'b0;
        tens_sel = idx_q[0];
        case (idx_q)
            3'd0, 3'd1: begin
                field    = secs_q;
                field_ok = (secs_q <= 6'd59);
            end
            3'd2, 3'd3: begin
                field    = mins_q;
                field_ok = (mins_q <= 6'd59);
            end
            3'd4, 3'd5: begin
                field    = {1'b0, hours_q};
                field_ok = (hours_q <= 5'd23);
            end
            default: begin
                field    = '0;
                field_ok = 1'b0;
            end
        endcase

        digit = tens_sel ? (field / 6'd10) : (field % 6'd10);
        seg_d = field_ok ? enc(digit) : SEG_DASH;
        an_d  = blink_q ? 6'b111111 : ~(6'b000001 << idx_q);
        dp_d  = ~((idx_q == 3'd2) || (idx_q == 3'd4));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            frame_q <= '0;
            blink_q <= 1'b0;
            hours_q <= '0;
            mins_q  <= '0;
            secs_q  <= '0;
            buzz_q  <= 1'b0;
            an_q    <= 6'b111111;
            seg_q   <= 7'b1111111;
            dp_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            blink_q <= blink_d;
            hours_q <= hours_d;
            mins_q  <= mins_d;
            secs_q  <= secs_d;
            buzz_q  <= buzz_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Directed bench for clock_display_scan with REFRESH_DIV=4, BLINK_FRAMES=2.
// Drives the time bus, checks an/seg/dp on the falling edge.
module tb_clock_display_scan;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SD = 7'b0111111;

    // {digit5, ..., digit0}
    localparam logic [41:0] F_NORM = {S1, S3, S4, S5, S2, S7};
    localparam logic [41:0] F_OOR  = {SD, SD, SD, SD, S0, S9};
    localparam logic [41:0] F_ZERO = {S0, S0, S0, S0, S0, S0};
    localparam logic [41:0] F_NEW  = {S0, S9, S0, S5, S5, S9};

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    clock_display_scan_if bus ();

    clock_display_scan #(
        .REFRESH_DIV  (4),
        .BLINK_FRAMES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [5:0] e_an,
                       input logic [6:0] e_seg, input logic e_dp);
        checks++;
        assert (bus.an === e_an) else begin
            errors++;
            $error("FAIL %s an=%b exp=%b", tag, bus.an, e_an);
        end
        checks++;
        assert (bus.seg === e_seg) else begin
            errors++;
            $error("FAIL %s seg=%b exp=%b", tag, bus.seg, e_seg);
        end
        checks++;
        assert (bus.dp === e_dp) else begin
            errors++;
            $error("FAIL %s dp=%b exp=%b", tag, bus.dp, e_dp);
        end
    endtask

    // Starts on the first cycle of digit 0, ends on digit 0 of the next frame.
    task automatic check_frame(input string tag, input logic [41:0] f,
                               input logic blank);
        logic [5:0] e_an;
        logic       e_dp;
        for (int i = 0; i < 6; i++) begin
            e_an = blank ? 6'b111111 : ~(6'b000001 << i);
            e_dp = (i == 2 || i == 4) ? 1'b0 : 1'b1;
            chk($sformatf("%s_d%0d", tag, i), e_an, f[i*7 +: 7], e_dp);
            step(4);
        end
    endtask

    task automatic set_time(input logic [4:0] h, input logic [5:0] m,
                            input logic [5:0] s, input logic b);
        bus.hours  = h;
        bus.mins   = m;
        bus.secs   = s;
        bus.buzzer = b;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        set_time(5'd13, 6'd45, 6'd27, 1'b0);

        step(3);
        chk("reset", 6'b111111, 7'b1111111, 1'b1);
        reset = 1'b0;

        step(1);
        chk("first_d0", 6'b111110, S0, 1'b1);
        step(3);
        chk("hold_d0", 6'b111110, S0, 1'b1);
        step(1);
        chk("first_d1", 6'b111101, S0, 1'b1);
        step(20);

        check_frame("norm", F_NORM, 1'b0);

        chk("coh_d0", 6'b111110, S7, 1'b1);
        step(12);
        set_time(5'd13, 6'd45, 6'd28, 1'b0);
        chk("coh_d3", 6'b110111, S4, 1'b1);
        step(4);
        chk("coh_d4", 6'b101111, S3, 1'b0);
        step(4);
        chk("coh_d5", 6'b011111, S1, 1'b1);
        step(4);
        chk("coh_next_d0", 6'b111110, S8, 1'b1);
        step(4);
        chk("coh_next_d1", 6'b111101, S2, 1'b1);

        set_time(5'd25, 6'd60, 6'd9, 1'b0);
        step(20);
        check_frame("oor", F_OOR, 1'b0);

        set_time(5'd13, 6'd45, 6'd27, 1'b1);
        step(24);
        check_frame("blk_f1", F_NORM, 1'b0);
        check_frame("blk_f2", F_NORM, 1'b0);
        check_frame("blk_f3", F_NORM, 1'b1);
        check_frame("blk_f4", F_NORM, 1'b1);
        check_frame("blk_f5", F_NORM, 1'b0);
        check_frame("blk_f6", F_NORM, 1'b0);
        set_time(5'd13, 6'd45, 6'd27, 1'b0);
        check_frame("blk_f7", F_NORM, 1'b1);
        check_frame("unblk_f1", F_NORM, 1'b0);
        check_frame("unblk_f2", F_NORM, 1'b0);

        set_time(5'd9, 6'd5, 6'd59, 1'b0);
        step(12);
        chk("pre_rst_d3", 6'b110111, S4, 1'b1);
        reset = 1'b1;
        step(1);
        chk("mid_reset", 6'b111111, 7'b1111111, 1'b1);
        reset = 1'b0;
        step(1);
        check_frame("post_rst", F_ZERO, 1'b0);
        check_frame("new_snap", F_NEW, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
